// File: rtl/fsquare.sv
// fsquare: multi-cycle binary32 squarer (y = x*x) with an iterative shift-add mantissa product and RNE rounding.
// Optional macro FSQUARE_EARLY_OUT_EN: zero/denormal/inf/NaN operands bypass MUL/NORM and complete on the accept edge.
module fsquare (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] x_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] y_o,
    output logic        exception_o
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_DONE} state_e;

`ifdef FSQUARE_EARLY_OUT_EN
    localparam bit EarlyOut = 1'b1;
`else
    localparam bit EarlyOut = 1'b0;
`endif

    state_e      state_q, state_d;
    logic [30:0] x_q, x_d;
    logic [47:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] y_q, y_d;
    logic        exc_q, exc_d;

    // The sign never reaches the result, so it is not stored.
    logic unused_sign;
    assign unused_sign = x_i[31];

    function automatic logic is_special(input logic [30:0] v);
        return (v[30:23] == 8'h00) || (v[30:23] == 8'hFF);
    endfunction

    // Returns {exception, y} for exponent fields 0 and 255.
    function automatic logic [32:0] special_res(input logic [30:0] v);
        if (v[30:23] == 8'h00)     return {1'b0, 32'h0000_0000};
        else if (v[22:0] != 23'd0) return {1'b1, 32'h7FC0_0000};
        else                       return {1'b0, 32'h7F80_0000};
    endfunction

    logic [23:0]       sig;
    logic signed [9:0] exp_pre, exp_n, exp_f;
    logic [22:0]       mant;
    logic              guard, sticky;
    logic [23:0]       mant_r;
    logic [32:0]       norm_res;

    always_comb begin
        sig     = {1'b1, x_q[22:0]};
        exp_pre = $signed({1'b0, x_q[30:23], 1'b0}) - 10'sd127;
        if (acc_q[47]) begin
            exp_n  = exp_pre + 10'sd1;
            mant   = acc_q[46:24];
            guard  = acc_q[23];
            sticky = |acc_q[22:0];
        end else begin
            exp_n  = exp_pre;
            mant   = acc_q[45:23];
            guard  = acc_q[22];
            sticky = |acc_q[21:0];
        end
        mant_r = {1'b0, mant} + {23'd0, guard & (sticky | mant[0])};
        // A carry out of rounding leaves mant_r[22:0] at zero, i.e. 1.0 at the next exponent.
        exp_f  = mant_r[23] ? exp_n + 10'sd1 : exp_n;
        if (is_special(x_q))        norm_res = special_res(x_q);
        else if (exp_f >= 10'sd255) norm_res = {1'b1, 32'h7F80_0000};
        else if (exp_f <= 10'sd0)   norm_res = 33'd0;
        else                        norm_res = {1'b0, 1'b0, exp_f[7:0], mant_r[22:0]};
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid_i)
                        state_d = (EarlyOut && is_special(x_i[30:0])) ? S_DONE : S_MUL;
            S_MUL:  if (cnt_q == 5'd23) state_d = S_NORM;
            S_NORM: state_d = S_DONE;
            S_DONE: if (out_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q == S_IDLE);
        out_valid_o = (state_q == S_DONE);
        y_o         = y_q;
        exception_o = exc_q;
    end

    always_comb begin
        x_d   = x_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        y_d   = y_q;
        exc_d = exc_q;
        case (state_q)
            S_IDLE: if (in_valid_i) begin
                x_d   = x_i[30:0];
                acc_d = 48'd0;
                cnt_d = 5'd0;
                if (EarlyOut && is_special(x_i[30:0])) {exc_d, y_d} = special_res(x_i[30:0]);
            end
            S_MUL: begin
                if (sig[cnt_q]) acc_d = acc_q + ({24'd0, sig} << cnt_q);
                cnt_d = cnt_q + 5'd1;
            end
            S_NORM: {exc_d, y_d} = norm_res;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            x_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            y_q   <= '0;
            exc_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            y_q   <= y_d;
            exc_q <= exc_d;
        end
    end

endmodule

// File: tb/tb_fsquare.sv
// Directed-vector bench for fsquare: result/flag/latency table plus back-pressure and mid-operation reset sequences.
module tb_fsquare;

`ifdef FSQUARE_EARLY_OUT_EN
    localparam int SpecLat = 1;
`else
    localparam int SpecLat = 26;
`endif
    localparam int FullLat = 26;

    logic        clk = 1'b0;
    logic        rstn, in_valid, in_ready, out_valid, out_ready, exc;
    logic [31:0] x, y;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fsquare dut (
        .clk_i(clk), .rstn_i(rstn), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .x_i(x), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .y_o(y), .exception_o(exc)
    );

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        exc;
        bit          special;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one operand, wait for the result, then take it with a one-cycle handshake.
    task automatic do_op(input logic [31:0] xv, output logic [31:0] yv, output logic ev, output int lat);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        x        = xv;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        x        = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        yv = y;
        ev = exc;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] yv;
        logic        ev;
        int          lat, n;

        vecs.push_back('{32'h4040_0000, 32'h4110_0000, 1'b0, 1'b0}); // 3.0
        vecs.push_back('{32'hC000_0000, 32'h4080_0000, 1'b0, 1'b0}); // -2.0
        vecs.push_back('{32'h3FC0_0000, 32'h4010_0000, 1'b0, 1'b0}); // 1.5
        vecs.push_back('{32'hC040_0000, 32'h4110_0000, 1'b0, 1'b0}); // -3.0
        vecs.push_back('{32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0}); // 1.0
        vecs.push_back('{32'h3FB5_04F3, 32'h3FFF_FFFF, 1'b0, 1'b0}); // ~sqrt2, no round-up
        vecs.push_back('{32'h3F80_0800, 32'h3F80_1000, 1'b0, 1'b0}); // exact tie, stays even
        vecs.push_back('{32'h3F80_0801, 32'h3F80_1003, 1'b0, 1'b0}); // above half, rounds up
        vecs.push_back('{32'h5F00_0000, 32'h7E80_0000, 1'b0, 1'b0}); // 2^63
        vecs.push_back('{32'h5F7F_FFFF, 32'h7F7F_FFFE, 1'b0, 1'b0}); // largest non-overflow
        vecs.push_back('{32'h5F80_0000, 32'h7F80_0000, 1'b1, 1'b0}); // 2^64 overflows
        vecs.push_back('{32'h60AD_78EC, 32'h7F80_0000, 1'b1, 1'b0}); // 1e20
        vecs.push_back('{32'h2000_0000, 32'h0080_0000, 1'b0, 1'b0}); // min normal result
        vecs.push_back('{32'h1F80_0000, 32'h0000_0000, 1'b0, 1'b0}); // underflow by one
        vecs.push_back('{32'h0DA2_4260, 32'h0000_0000, 1'b0, 1'b0}); // 1e-30
        vecs.push_back('{32'h7FC0_0001, 32'h7FC0_0000, 1'b1, 1'b1}); // NaN
        vecs.push_back('{32'hFFC0_0000, 32'h7FC0_0000, 1'b1, 1'b1}); // negative NaN
        vecs.push_back('{32'hFF80_0000, 32'h7F80_0000, 1'b0, 1'b1}); // -inf
        vecs.push_back('{32'h7F80_0000, 32'h7F80_0000, 1'b0, 1'b1}); // +inf
        vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1}); // +0
        vecs.push_back('{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1}); // -0
        vecs.push_back('{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1}); // denormal

        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready",  {31'd0, in_ready},  32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_y",         y,                  32'd0);
        check("reset_exc",       {31'd0, exc},       32'd0);
        @(negedge clk);
        rstn = 1'b1;

        foreach (vecs[i]) begin
            do_op(vecs[i].x, yv, ev, lat);
            check($sformatf("vec%0d_y", i),   yv,              vecs[i].y);
            check($sformatf("vec%0d_exc", i), {31'd0, ev},     {31'd0, vecs[i].exc});
            check($sformatf("vec%0d_lat", i), lat,             vecs[i].special ? SpecLat : FullLat);
        end

        // Back-pressure: DONE holds with the input side toggling.
        @(negedge clk);
        in_valid = 1'b1;
        x        = 32'h4040_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            x        = $urandom;
            in_valid = i[0];
            check("hold_y",         y,                  32'h4110_0000);
            check("hold_exc",       {31'd0, exc},       32'd0);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_in_ready",  {31'd0, in_ready},  32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_in_ready",  {31'd0, in_ready},  32'd1);
        check("release_out_valid", {31'd0, out_valid}, 32'd0);

        // Reset while the MUL counter is at 10 aborts the operation.
        @(negedge clk);
        in_valid = 1'b1;
        x        = 32'h3FC0_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready",  {31'd0, in_ready},  32'd1);
        check("abort_y",         y,                  32'd0);
        check("abort_exc",       {31'd0, exc},       32'd0);
        do_op(32'h4040_0000, yv, ev, lat);
        check("after_abort_y",   yv,          32'h4110_0000);
        check("after_abort_exc", {31'd0, ev}, 32'd0);
        check("after_abort_lat", lat,         FullLat);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
